// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: opcode classes,
// buffered entry layout and the opcode classifier.
package fetch_pkg;

    typedef enum logic [1:0] {
        TYPE_ALU_I   = 2'd0,
        TYPE_ALU_R   = 2'd1,
        TYPE_MEM     = 2'd2,
        TYPE_ILLEGAL = 2'd3
    } instr_type_e;

    localparam logic [6:0] OPC_ALU_I = 7'h13;
    localparam logic [6:0] OPC_ALU_R = 7'h33;
    localparam logic [6:0] OPC_MEM   = 7'h03;

    // Widest word address an entry can carry; the top
    // narrows it to the real PC width.
    localparam int PC_MAX_W = 16;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_MAX_W-1:0] pc;
        instr_type_e         itype;
    } fetch_entry_t;

    function automatic instr_type_e classify(
        input logic [6:0] opc
    );
        instr_type_e t;
        t = TYPE_ILLEGAL;
        unique case (1'b1)
            (opc == OPC_ALU_I): t = TYPE_ALU_I;
            (opc == OPC_ALU_R): t = TYPE_ALU_R;
            (opc == OPC_MEM):   t = TYPE_MEM;
            default:            t = TYPE_ILLEGAL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decoder handshake: valid/ready plus head payload.
// master = fetch unit (drives payload), slave = decoder.
interface instr_fetch_unit_if #(
    parameter int MEM_DEPTH = 64
);
    import fetch_pkg::*;

    localparam int PC_W = $clog2(MEM_DEPTH);

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    instr_type_e     out_type;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        output out_type,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_type,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO, type-parameterised entries.
// Ports: clock, reset (async high), push/din, pop/dout, count, empty.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    assign dout   = mem[rd_ptr];

    // Storage needs no reset: nothing reads it while empty.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Upstream credit accounting must never let this happen.
    a_no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        !(push && full)
    );

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: pulls words from memory via next_op/instr_in,
// tags them with pc and opcode class, buffers them, and offers the
// head to the decoder over valid/ready.
// Ports: clock, reset (async high), fetch_en, next_op, instr_in,
//        dec (master handshake: out_valid/ready/instr/pc/type),
//        fifo_count; with FETCH_PERF_CNT_EN also perf_fetched and
//        perf_stall (saturating 32-bit counters).
// The memory shares this reset (its reset_n is ~reset).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        fetch_en,
    output logic                        next_op,
    input  logic [31:0]                 instr_in,
    instr_fetch_unit_if.master          dec,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_fetched,
    output logic [31:0]                 perf_stall
`endif
);

    localparam int PC_W  = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PC_W-1:0] issue_pc;
    logic [PC_W-1:0] req_pc;
    logic [PC_W-1:0] next_pc;
    logic            inflight;
    logic [CNT_W:0]  used;
    logic            push;
    logic            pop;
    logic            empty;
    fetch_entry_t    entry;
    fetch_entry_t    head;
    logic            unused_pc_hi;

    // Buffered plus in-flight words; a pop this cycle does not
    // release credit until the count has actually dropped.
    assign used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};

    assign next_op = fetch_en && !reset &&
                     (used < (CNT_W+1)'(FIFO_DEPTH));

    assign next_pc = (issue_pc == PC_W'(MEM_DEPTH - 1)) ?
                     '0 : issue_pc + PC_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_pc <= '0;
            req_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= next_op;
            if (next_op) begin
                req_pc   <= issue_pc;
                issue_pc <= next_pc;
            end
        end
    end

    // Memory answers one cycle after the request: capture then only.
    assign push = inflight;

    always_comb begin
        entry       = '0;
        entry.instr = instr_in;
        entry.pc    = PC_MAX_W'(req_pc);
        entry.itype = classify(instr_in[6:0]);
    end

    assign pop = dec.out_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (empty)
    );

    // Payload is forced to its idle value while nothing is buffered.
    assign dec.out_valid = !empty;
    assign dec.out_instr = empty ? '0 : head.instr;
    assign dec.out_pc    = empty ? '0 : head.pc[PC_W-1:0];
    assign dec.out_type  = empty ? TYPE_ILLEGAL : head.itype;

    assign unused_pc_hi = ^head.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (dec.out_ready && empty && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a behavioural
// next_op/instr memory model.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int MD = 64;
    localparam int FD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        next_op;
    logic [31:0] instr_in;
    logic [2:0]  fifo_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit_if #(.MEM_DEPTH(MD)) dec_if ();

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .MEM_DEPTH  (MD),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .next_op    (next_op),
        .instr_in   (instr_in),
        .dec        (dec_if),
        .fifo_count (fifo_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // Memory image: I/R/MEM repeating, last word a JAL (illegal class).
    function automatic logic [31:0] mem_word(input int a);
        if (a == MD - 1) return 32'h0000_006F;
        case (a % 3)
            0:       return 32'h00A0_0093;
            1:       return 32'h0010_8133;
            default: return 32'h0020_8203;
        endcase
    endfunction

    function automatic instr_type_e exp_type(input int a);
        if (a == MD - 1) return TYPE_ILLEGAL;
        case (a % 3)
            0:       return TYPE_ALU_I;
            1:       return TYPE_ALU_R;
            default: return TYPE_MEM;
        endcase
    endfunction

    logic       mem_reset_n;
    logic [5:0] mem_addr;
    assign mem_reset_n = ~reset;

    always @(posedge clock or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            mem_addr <= '0;
            instr_in <= '0;
        end else if (next_op) begin
            instr_in <= mem_word(int'(mem_addr));
            mem_addr <= mem_addr + 6'd1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        int          pc;
        instr_type_e t;
    } exp_t;

    exp_t sb[$];
    int   pop_pcs[$];
    int   exp_pc  = 0;
    int   req_cnt = 0;
    int   pop_cnt = 0;
    int   last_pc = 0;
    int   prev_pc = 0;
    logic wrap_seen = 1'b0;
    logic [31:0] wrap_instr = '0;

    // Monitor: push expectation per request, compare per pop.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                exp_pc = 0;
            end else begin
                if (dec_if.out_valid && dec_if.out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("sb_instr", dec_if.out_instr, e.instr);
                        check("sb_pc", 32'(dec_if.out_pc), 32'(e.pc));
                        check("sb_type", 32'(dec_if.out_type), 32'(e.t));
                    end
                    prev_pc = last_pc;
                    last_pc = int'(dec_if.out_pc);
                    pop_pcs.push_back(last_pc);
                    pop_cnt++;
                    if (prev_pc == MD - 1 && last_pc == 0) begin
                        wrap_seen  = 1'b1;
                        wrap_instr = dec_if.out_instr;
                    end
                end
                if (next_op) begin
                    e.instr = mem_word(exp_pc);
                    e.pc    = exp_pc;
                    e.t     = exp_type(exp_pc);
                    sb.push_back(e);
                    exp_pc = (exp_pc + 1) % MD;
                    req_cnt++;
                end
            end
        end
    end

    task automatic at_neg();
        @(negedge clock);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic fe, input logic rdy);
        at_pos();
        reset = 1'b1;
        fetch_en = fe;
        dec_if.out_ready = rdy;
        at_pos();
        at_pos();
        reset = 1'b0;
        pop_pcs.delete();
    endtask

    initial begin
        int r0;
        int p0;
        int k;
        dec_if.out_ready = 1'b0;

        // Reset values
        at_neg();
        check("rst_next_op", 32'(next_op), 32'd0);
        check("rst_valid", 32'(dec_if.out_valid), 32'd0);
        check("rst_instr", dec_if.out_instr, 32'd0);
        check("rst_pc", 32'(dec_if.out_pc), 32'd0);
        check("rst_type", 32'(dec_if.out_type), 32'(TYPE_ILLEGAL));
        check("rst_count", 32'(fifo_count), 32'd0);

        // Startup latency and first three words
        do_reset(1'b1, 1'b1);
        at_neg();
        check("c0_next_op", 32'(next_op), 32'd1);
        at_neg();
        check("c1_valid", 32'(dec_if.out_valid), 32'd0);
        at_neg();
        check("c2_valid", 32'(dec_if.out_valid), 32'd1);
        check("c2_instr", dec_if.out_instr, 32'h00A0_0093);
        check("c2_pc", 32'(dec_if.out_pc), 32'd0);
        check("c2_type", 32'(dec_if.out_type), 32'(TYPE_ALU_I));
        at_neg();
        check("c3_instr", dec_if.out_instr, 32'h0010_8133);
        check("c3_pc", 32'(dec_if.out_pc), 32'd1);
        check("c3_type", 32'(dec_if.out_type), 32'(TYPE_ALU_R));
        at_neg();
        check("c4_instr", dec_if.out_instr, 32'h0020_8203);
        check("c4_pc", 32'(dec_if.out_pc), 32'd2);
        check("c4_type", 32'(dec_if.out_type), 32'(TYPE_MEM));

        // Backpressure: four credits, then stall
        do_reset(1'b1, 1'b0);
        r0 = req_cnt;
        repeat (10) at_neg();
        check("bp_reqs", 32'(req_cnt - r0), 32'd4);
        check("bp_count", 32'(fifo_count), 32'd4);
        check("bp_next_op", 32'(next_op), 32'd0);
        check("bp_hold_pc", 32'(dec_if.out_pc), 32'd0);
        at_pos();
        dec_if.out_ready = 1'b1;
        repeat (4) at_neg();
        check("drain_n", 32'(pop_pcs.size()), 32'd4);
        for (int i = 0; i < 4 && i < pop_pcs.size(); i++) begin
            check("drain_pc", 32'(pop_pcs[i]), 32'(i));
        end

        // PC wrap over 70 accepted fetches
        wrap_seen = 1'b0;
        p0 = pop_cnt;
        k = 0;
        while (pop_cnt - p0 < 70 && k < 300) begin
            at_neg();
            k++;
        end
        check("wrap_progress", 32'(pop_cnt - p0 >= 70), 32'd1);
        check("wrap_seen", 32'(wrap_seen), 32'd1);
        check("wrap_instr", wrap_instr, 32'h00A0_0093);

        // fetch_en drop right after an accepted request
        do_reset(1'b1, 1'b1);
        at_neg();
        check("fe_next_op", 32'(next_op), 32'd1);
        r0 = req_cnt;
        p0 = pop_cnt;
        at_pos();
        fetch_en = 1'b0;
        repeat (10) at_neg();
        check("fe_no_req", 32'(req_cnt - r0), 32'd0);
        check("fe_delivered", 32'(pop_cnt - p0), 32'd1);
        check("fe_pc", 32'(last_pc), 32'd0);
        check("fe_count", 32'(fifo_count), 32'd0);

        // Reset with 3 buffered and 1 in flight
        do_reset(1'b1, 1'b0);
        k = 0;
        at_neg();
        while (fifo_count != 3'd3 && k < 20) begin
            at_neg();
            k++;
        end
        check("mr_count3", 32'(fifo_count), 32'd3);
        check("mr_no_issue", 32'(next_op), 32'd0);
        at_pos();
        reset = 1'b1;
        at_neg();
        check("mr_valid", 32'(dec_if.out_valid), 32'd0);
        check("mr_count", 32'(fifo_count), 32'd0);
        at_pos();
        reset = 1'b0;
        dec_if.out_ready = 1'b1;
        p0 = pop_cnt;
        k = 0;
        while (pop_cnt == p0 && k < 20) begin
            at_neg();
            k++;
        end
        check("mr_popped", 32'(pop_cnt - p0 >= 1), 32'd1);
        check("mr_first_pc", 32'(pop_pcs.size() > 0 ? pop_pcs[0] : -1),
              32'd0);

`ifdef FETCH_PERF_CNT_EN
        // Counters over the first 20 cycles after reset
        do_reset(1'b1, 1'b1);
        repeat (20) at_neg();
        check("perf_stall", perf_stall, 32'd2);
        check("perf_fetched", perf_fetched, 32'd18);
`endif

        repeat (3) at_neg();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Consumer side of the instruction memory's next_op/instr interface. Pulses next_op to pull sequential words and captures the instruction the memory presents one cycle later. Buffers words in a small prefetch FIFO, tagging each with its word address and a coarse opcode class. Hands them to the decoder over a valid/ready handshake.

Parameters:
MEM_DEPTH, 64, word depth of the instruction memory; the PC wraps modulo this value; power of 2.
FIFO_DEPTH, 4, prefetch buffer entries; power of 2, >= 2.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high. The top level drives memory reset_n = ~reset so both sides reset together.
fetch_en  input  1  permits new memory requests.
next_op  output  1  request to memory; combinational from registered state and fetch_en.
instr_in  input  32  memory instruction output; valid in the cycle after next_op.
out_valid  output  1  FIFO head is valid.
out_ready  input  1  decoder accepts the head.
out_instr  output  32  head instruction.
out_pc  output  $clog2(MEM_DEPTH)  word address of the head.
out_type  output  2  head class (instr_type_e).
fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: next_op=0, out_valid=0, out_instr=0, out_pc=0, out_type=TYPE_ILLEGAL, fifo_count=0. Internal state also clears: issue_pc=0, inflight=0.
- Issue rule: next_op = fetch_en && !reset && (fifo_count + inflight) < FIFO_DEPTH. A pop in the same cycle does not release credit; credit frees on the next cycle.
- inflight <= next_op every cycle.
- req_pc <= issue_pc when next_op is high.
- issue_pc increments on next_op and wraps from MEM_DEPTH-1 to 0, matching the memory's address wrap.
- Capture: when inflight=1, push {instr_in, req_pc, class(instr_in)} into the FIFO. No other cycle samples instr_in; the held value is ignored.
- Latency: next_op high in cycle t, push at the end of t+1, out_valid high in t+2. There is no bypass path.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.
- Pop on out_valid && out_ready.
- out_* stays stable while out_valid && !out_ready.
- Simultaneous push and pop: occupancy unchanged; ordering preserved.
- Full: the credit rule guarantees no push while full. An overflow attempt is an assertion failure, not silent loss.
- Empty with pop request: out_valid=0, nothing happens.
- fetch_en deasserted with a request in flight: the in-flight word is still captured; no new requests issue.
- Reset mid-operation: the in-flight word is dropped, FIFO and PC clear, and the first post-reset fetch is pc 0.
- Classification by instr_in[6:0]:
  - 0x13 -> TYPE_ALU_I
  - 0x33 -> TYPE_ALU_R
  - 0x03 -> TYPE_MEM
  - anything else -> TYPE_ILLEGAL

Optional Feature:
FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_stall[31:0].
  - perf_fetched counts pushes.
  - perf_stall counts cycles with out_ready && !out_valid.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- fetch_pkg holds:
  - enum instr_type_e {TYPE_ALU_I=0, TYPE_ALU_R=1, TYPE_MEM=2, TYPE_ILLEGAL=3}
  - opcode constants OPC_ALU_I=7'h13, OPC_ALU_R=7'h33, OPC_MEM=7'h03
  - struct fetch_entry_t {instr, pc, type}
- Sub-module fetch_fifo: synchronous FIFO parameterised on DEPTH and entry type, with push/pop/count and asynchronous active-high reset.

Test Plan:
- Reset, fetch_en=1, out_ready=1, memory preloaded with the I/R/MEM repeating pattern:
  - next_op in cycle 0; first out_valid in cycle 2 with 0x00A00093, pc 0, TYPE_ALU_I.
  - Then 0x00108133, pc 1, TYPE_ALU_R.
  - Then 0x00208203, pc 2, TYPE_MEM.
- out_ready=0 for 10 cycles: exactly 4 requests issue, fifo_count=4, next_op stays low. out_ready=1 then drains pc 0..3 in order with no gaps or duplicates.
- Run 70 accepted fetches: out_pc wraps 63 -> 0; the instruction at pc 0 after the wrap is 0x00A00093.
- Deassert fetch_en in the same cycle next_op is high: that word is still delivered, and no further next_op is issued.
- Assert reset while 3 entries are buffered and 1 is in flight: the next cycle shows out_valid=0 and fifo_count=0; after release, the first output is pc 0.
- With FETCH_PERF_CNT_EN defined: hold out_ready=1 from reset for 20 cycles with fetch_en=1. Required: perf_stall=2 (the two startup cycles) and perf_fetched=18.
